// File: rtl/iterative_alu_mdu.sv
// RV32I ALU plus RV32M multiply/divide execute unit. Base ops finish in one cycle;
// multiply/divide iterate one bit per cycle over WIDTH cycles behind valid/ready handshakes.
module iterative_alu_mdu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int CNT_W   = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  input  logic [4:0]       i_alu_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_alu_data,
  output logic             o_busy
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   opb;
  logic               neg;
  logic               hi_sel;
  logic               rem_sel;
  logic               div_op;

  assign o_ready = (state == S_IDLE);

  // ---------------- single-cycle base ALU ----------------
  logic [SHAMT_W-1:0]      shamt;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic [WIDTH-1:0]        base_res;

  assign shamt = i_operand_b[SHAMT_W-1:0];
  assign a_s   = i_operand_a;
  assign b_s   = i_operand_b;

  always_comb begin
    base_res = '0;
    case (i_alu_op[3:0])
      4'b0000: base_res = i_operand_a + i_operand_b;
      4'b1000: base_res = i_operand_a - i_operand_b;
      4'b0001: base_res = i_operand_a << shamt;
      4'b0010: base_res = {{(WIDTH-1){1'b0}}, a_s < b_s};
      4'b0011: base_res = {{(WIDTH-1){1'b0}}, i_operand_a < i_operand_b};
      4'b0100: base_res = i_operand_a ^ i_operand_b;
      4'b0101: base_res = i_operand_a >> shamt;
      4'b1101: base_res = a_s >>> shamt;
      4'b0110: base_res = i_operand_a | i_operand_b;
      4'b0111: base_res = i_operand_a & i_operand_b;
      4'b1111: base_res = i_operand_b;
      default: base_res = '0;
    endcase
  end

  // ---------------- M-op operand preparation ----------------
  logic [2:0]       f3;
  logic             is_div;
  logic             a_signed;
  logic             b_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             div_ovf;

  assign f3       = i_alu_op[2:0];
  assign is_div   = f3[2];
  assign a_signed = is_div ? ~f3[0] : (f3[1:0] == 2'b01 || f3[1:0] == 2'b10);
  assign b_signed = is_div ? ~f3[0] : (f3[1:0] == 2'b01);
  assign a_neg    = a_signed & i_operand_a[WIDTH-1];
  assign b_neg    = b_signed & i_operand_b[WIDTH-1];
  assign a_mag    = a_neg ? ('0 - i_operand_a) : i_operand_a;
  assign b_mag    = b_neg ? ('0 - i_operand_b) : i_operand_b;
  assign div_zero = (i_operand_b == '0);
  assign div_ovf  = ~f3[0] && (i_operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (i_operand_b == '1);

  // ---------------- iteration datapath ----------------
  // Multiply: multiplier sits in acc low half and shifts out as the product shifts in.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & opb};

  // Divide: dividend in acc low half shifts into the WIDTH+1-bit partial remainder,
  // quotient bits shift in behind it. Borrow bit of the trial subtract decides.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] rem_nxt;
  assign div_shift = {rem, acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb};
  assign div_ge    = ~div_diff[WIDTH];
  assign rem_nxt   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

  // ---------------- sign fix-up ----------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   div_pick;
  logic [WIDTH-1:0]   fix_res;
  assign prod_fix = neg ? ('0 - acc) : acc;
  assign div_pick = rem_sel ? rem : acc[WIDTH-1:0];
  assign fix_res  = div_op ? (neg ? ('0 - div_pick) : div_pick)
                           : (hi_sel ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0]);

  // ---------------- control FSM ----------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= S_IDLE;
      o_valid    <= 1'b0;
      o_alu_data <= '0;
      o_busy     <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      rem        <= '0;
      opb        <= '0;
      neg        <= 1'b0;
      hi_sel     <= 1'b0;
      rem_sel    <= 1'b0;
      div_op     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            cnt <= '0;
            if (!i_alu_op[4]) begin
              o_alu_data <= base_res;
              o_valid    <= 1'b1;
              state      <= S_DONE;
            end else if (is_div && div_zero) begin
              o_alu_data <= f3[1] ? i_operand_a : '1;
              o_valid    <= 1'b1;
              state      <= S_DONE;
            end else if (is_div && div_ovf) begin
              o_alu_data <= f3[1] ? '0 : i_operand_a;
              o_valid    <= 1'b1;
              state      <= S_DONE;
            end else begin
              o_busy  <= 1'b1;
              div_op  <= is_div;
              hi_sel  <= (f3[1:0] != 2'b00);
              rem_sel <= f3[1];
              // remainder follows the dividend; quotient/product follow the sign XOR
              neg     <= (is_div && f3[1]) ? a_neg : (a_neg ^ b_neg);
              rem     <= '0;
              if (is_div) begin
                acc   <= {{WIDTH{1'b0}}, a_mag};
                opb   <= b_mag;
                state <= S_DIV;
              end else begin
                acc   <= {{WIDTH{1'b0}}, b_mag};
                opb   <= a_mag;
                state <= S_MUL;
              end
            end
          end
        end
        S_MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) state <= S_FIXUP;
        end
        S_DIV: begin
          rem             <= rem_nxt;
          acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], div_ge};
          cnt             <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) state <= S_FIXUP;
        end
        S_FIXUP: begin
          o_alu_data <= fix_res;
          o_valid    <= 1'b1;
          o_busy     <= 1'b0;
          state      <= S_DONE;
        end
        S_DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_alu_mdu.sv
// Scoreboard bench for iterative_alu_mdu: driver pushes hand-computed results and
// latencies, a negedge monitor pops and compares whenever o_valid is presented.
module tb_iterative_alu_mdu;

  logic        i_clk;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_operand_a;
  logic [31:0] i_operand_b;
  logic [4:0]  i_alu_op;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_alu_data;
  logic        o_busy;

  iterative_alu_mdu #(.WIDTH(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_operand_a(i_operand_a), .i_operand_b(i_operand_b), .i_alu_op(i_alu_op),
    .o_valid(o_valid), .i_ready(i_ready), .o_alu_data(o_alu_data), .o_busy(o_busy)
  );

  localparam logic [4:0] OP_ADD = 5'h00, OP_SUB = 5'h08, OP_SLL = 5'h01, OP_SLT = 5'h02,
                         OP_SLTU = 5'h03, OP_XOR = 5'h04, OP_SRL = 5'h05, OP_SRA = 5'h0D,
                         OP_OR = 5'h06, OP_AND = 5'h07, OP_LUI = 5'h0F, OP_UND = 5'h09;
  localparam logic [4:0] OP_MUL = 5'h10, OP_MULH = 5'h11, OP_MULHSU = 5'h12, OP_MULHU = 5'h13,
                         OP_DIV = 5'h14, OP_DIVU = 5'h15, OP_REM = 5'h16, OP_REMU = 5'h17;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   seen  = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor: latency on first sight, hold-stability under back-pressure, data on handshake.
  always @(negedge i_clk) begin
    if (!i_reset && o_valid) begin
      if (sb.size() == 0) begin
        check("unexpected o_valid", {31'b0, o_valid}, 32'd0);
      end else begin
        if (!seen) begin
          check({sb[0].name, " latency"}, cyc - sb[0].acyc + 1, sb[0].lat);
          seen = 1;
        end
        check(sb[0].name, o_alu_data, sb[0].data);
        if (i_ready) begin
          void'(sb.pop_front());
          seen = 0;
        end else begin
          check({sb[0].name, " o_ready held low"}, {31'b0, o_ready}, 32'd0);
        end
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input int lat, input string nm);
    exp_t e;
    int   w;
    w = 0;
    @(negedge i_clk);
    while (!o_ready && w < 200) begin
      @(negedge i_clk);
      w++;
    end
    if (!o_ready) begin
      check({nm, " o_ready timeout"}, {31'b0, o_ready}, 32'd1);
      return;
    end
    i_valid = 1'b1; i_alu_op = op; i_operand_a = a; i_operand_b = b;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    e.data = expv; e.lat = lat; e.acyc = cyc; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge i_clk);
      w++;
    end
    if (sb.size() != 0) begin
      check({sb[0].name, " result timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
      seen = 0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit hit, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_operand_a = '0; i_operand_b = '0; i_alu_op = '0;
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    check("reset o_valid", {31'b0, o_valid}, 32'd0);
    check("reset o_alu_data", o_alu_data, 32'd0);
    check("reset o_busy", {31'b0, o_busy}, 32'd0);
    check("reset o_ready", {31'b0, o_ready}, 32'd1);

    // base ALU
    issue(OP_ADD,  32'd5,        32'hFFFFFFFD, 32'h00000002, 1, "ADD wrap");
    issue(OP_SRA,  32'h80000000, 32'h00000024, 32'hF8000000, 1, "SRA shamt4");
    issue(OP_SLTU, 32'd1,        32'hFFFFFFFF, 32'd1,        1, "SLTU");
    issue(OP_SLT,  32'd1,        32'hFFFFFFFF, 32'd0,        1, "SLT");
    issue(OP_SUB,  32'd3,        32'd5,        32'hFFFFFFFE, 1, "SUB");
    issue(OP_SLL,  32'd1,        32'h00000021, 32'd2,        1, "SLL shamt1");
    issue(OP_SRL,  32'h80000000, 32'd4,        32'h08000000, 1, "SRL");
    issue(OP_XOR,  32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1, "XOR");
    issue(OP_OR,   32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1, "OR");
    issue(OP_AND,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1, "AND");
    issue(OP_LUI,  32'hDEADBEEF, 32'h12345000, 32'h12345000, 1, "LUI");
    issue(OP_UND,  32'd5,        32'd6,        32'd0,        1, "undefined op");
    drain();

    // multiply
    issue(OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, "MUL 7*-3");
    @(negedge i_clk);
    check("MUL o_busy", {31'b0, o_busy}, 32'd1);
    check("MUL o_ready", {31'b0, o_ready}, 32'd0);
    issue(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, "MULH min*min");
    issue(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "MULHU max*max");
    issue(OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, "MULHSU -1*2");
    issue(OP_MULH,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 34, "MULH 7*-3");

    // divide, including single-cycle special cases
    issue(OP_DIV,  32'd7,        32'd0,        32'hFFFFFFFF, 1,  "DIV by zero");
    issue(OP_REM,  32'd7,        32'd0,        32'h00000007, 1,  "REM by zero");
    issue(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "DIV overflow");
    issue(OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  "REM overflow");
    issue(OP_REMU, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1,  "REMU by zero");
    issue(OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, "REM -7/2");
    issue(5'h1C,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, "DIV -7/2 bit3 set");
    issue(OP_REMU, 32'd100,      32'd7,        32'd2,        34, "REMU 100/7");
    drain();

    // back-pressure: result must hold while i_ready=0; i_valid pulses are ignored
    i_ready = 1'b0;
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 34, "DIVU backpressure");
    w = 0;
    while (!o_valid && w < 100) begin
      @(negedge i_clk);
      w++;
    end
    check("DIVU o_valid seen", {31'b0, o_valid}, 32'd1);
    i_alu_op = OP_ADD; i_operand_a = 32'd1; i_operand_b = 32'd1;
    repeat (5) begin
      @(posedge i_clk);
      #1 i_valid = ~i_valid;
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    drain();
    @(negedge i_clk);
    check("post-backpressure o_valid", {31'b0, o_valid}, 32'd0);
    check("post-backpressure o_ready", {31'b0, o_ready}, 32'd1);

    // reset mid-multiply aborts with no result
    issue(OP_MUL, 32'd123, 32'd456, 32'd56088, 34, "MUL aborted");
    repeat (9) @(negedge i_clk);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1 i_reset = 1'b0;
    sb.delete();
    seen = 0;
    @(negedge i_clk);
    check("abort o_valid", {31'b0, o_valid}, 32'd0);
    check("abort o_busy", {31'b0, o_busy}, 32'd0);
    check("abort o_ready", {31'b0, o_ready}, 32'd1);
    issue(OP_ADD, 32'd1, 32'd1, 32'd2, 1, "ADD after reset");
    drain();
    repeat (3) @(negedge i_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
